// File: rtl/ifu_fetch_buf.sv
// rtl/ifu_fetch_buf.sv - instruction fetch unit with prefetch buffer
//
// Owns the fetch PC. Issues word reads to a one-cycle-latency instruction
// SRAM and buffers the returned words with their PC. Decode drains the buffer
// over a valid/ready handshake. A redirect flushes buffered and in-flight
// fetches and restarts fetch at redirect_pc.
//
// Parameters:
//   RESET_PC     fetch PC after reset (word aligned)
//   DEPTH        prefetch buffer entries (power of two, 2..8)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   ins_a        SRAM byte address (bits [1:0] always 0)
//   ins_e        SRAM fetch request
//   ins          SRAM read data, valid the cycle after the request edge
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  restart address (bits [1:0] ignored)
//   out_vld      buffer head valid
//   out_rdy      decode accepts head
//   out_pc       PC of head entry
//   out_ins      instruction word of head entry
//
// Optional feature macro: IFU_JAL_PREDECODE_EN
//   When defined, a pushed JAL steers the next fetch to its target.

module ifu_fetch_buf #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] ins_a,
   output logic        ins_e,
   input  logic [31:0] ins,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        out_vld,
   input  logic        out_rdy,
   output logic [15:0] out_pc,
   output logic [31:0] out_ins
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [15:0]   pc;
   logic [15:0]   infl_pc;
   logic          infl;
   logic [15:0]   pc_mem  [DEPTH];
   logic [31:0]   ins_mem [DEPTH];
   logic [AW-1:0] rptr;
   logic [AW-1:0] wptr;
   logic [CW-1:0] count;

   logic          push;
   logic          pop;
   logic [CW:0]   occ_next;
   logic [15:0]   redirect_pc_al;
   logic [15:0]   pc_nxt;
   logic          infl_nxt;

   assign redirect_pc_al = redirect_pc & 16'hFFFC;

   // A handshake during a redirect cycle is not a transfer: the buffer is
   // being flushed anyway.
   assign pop  = out_vld && out_rdy && !redirect;
   assign push = infl && !redirect;

   // Occupancy the buffer must absorb if we issue now: stored entries plus
   // the in-flight word, minus what leaves this cycle.
   assign occ_next = {1'b0, count} + {{CW{1'b0}}, infl} - {{CW{1'b0}}, pop};
   assign ins_e    = !rst && !redirect && (occ_next < (CW+1)'(DEPTH));
   assign ins_a    = pc;

   assign out_vld  = (count != '0);
   assign out_pc   = pc_mem[rptr];
   assign out_ins  = ins_mem[rptr];

`ifdef IFU_JAL_PREDECODE_EN
   // J-immediate truncated to 16 bits: only imm[15:0] can affect the
   // 16-bit target.
   logic [15:0] j_imm;
   logic [15:0] jal_target;
   logic        jal_hit;

   assign j_imm      = {ins[15:12], ins[20], ins[30:21], 1'b0};
   assign jal_target = (infl_pc + j_imm) & 16'hFFFC;
   assign jal_hit    = push && (ins[6:0] == 7'b1101111);
`endif

   always_comb begin
      pc_nxt   = pc;
      infl_nxt = 1'b0;
      if (redirect) begin
         pc_nxt   = redirect_pc_al;
         infl_nxt = 1'b0;
      end else begin
         if (ins_e) begin
            pc_nxt = pc + 16'd4;
         end
         infl_nxt = ins_e;
`ifdef IFU_JAL_PREDECODE_EN
         // Any sequential request issued alongside the JAL push fetched
         // the fall-through word, so its response is dropped.
         if (jal_hit) begin
            pc_nxt   = jal_target;
            infl_nxt = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= RESET_PC;
         infl    <= 1'b0;
         infl_pc <= '0;
         rptr    <= '0;
         wptr    <= '0;
         count   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]  <= '0;
            ins_mem[i] <= '0;
         end
      end else begin
         pc   <= pc_nxt;
         infl <= infl_nxt;
         if (ins_e) begin
            infl_pc <= pc;
         end
         if (redirect) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
         end else begin
            if (push) begin
               pc_mem[wptr]  <= infl_pc;
               ins_mem[wptr] <= ins;
               wptr          <= wptr + AW'(1);
            end
            if (pop) begin
               rptr <= rptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // The issue rule keeps count + infl <= DEPTH, so a push into a full
   // buffer without a matching pop means that rule is broken.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(push && !pop && count == CW'(DEPTH)));
      end
   end

endmodule

// File: doc/ifu_fetch_buf.md
# ifu_fetch_buf

Instruction fetch unit with a small prefetch buffer, sitting between the instruction SRAM port (`ins_a`/`ins_e`/`ins`) and the decode/execute stage of the core. It owns the fetch PC and issues word reads to the one-cycle-latency instruction SRAM. Returned words are buffered together with their PC and presented to decode over a valid/ready handshake. A redirect from execute (taken branch/jump) flushes both buffered and in-flight fetches.

## Interface
- `RESET_PC`, 16'h0000: fetch PC loaded on reset; word-aligned.
- `DEPTH`, 2: prefetch buffer entries; power of two, 2..8.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ins_a`  out  16  instruction byte address to SRAM; bits [1:0] always 0.
- `ins_e`  out  1  fetch request; SRAM samples `ins_a` on the same rising edge.
- `ins`  in  32  SRAM read data, valid the whole cycle after the request edge.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  16  new fetch address; bits [1:0] ignored (treated as 0).
- `out_vld`  out  1  buffer head valid.
- `out_rdy`  in  1  decode accepts head.
- `out_pc`  out  16  PC of head entry.
- `out_ins`  out  32  instruction word of head entry.

## Operation
- State: `pc` (next fetch address), `infl` (1 bit, request issued last cycle and not killed), FIFO of `DEPTH` entries {pc, ins}, read/write pointers, `count` (0..DEPTH).
- `ins_a = pc`, combinational from register.
- Issue: `ins_e = !redirect && (count + infl - pop < DEPTH)`, where pop = `out_vld && out_rdy && !redirect`. On issue, `pc <= pc + 4` (16-bit wrap, 16'hFFFC -> 16'h0000).
- Response: if `infl`=1 and no redirect this cycle, push {pc of that request, `ins`} at the edge. Issued PC is held in a 16-bit `infl_pc` register.
- Pop: pop advances the read pointer. Simultaneous push and pop are legal at any occupancy, including full; `count` is unchanged.
- Redirect (`redirect`=1): at the edge, `count <= 0`, pointers reset, `infl <= 0` (the response arriving next cycle is discarded), `pc <= {redirect_pc[15:2],2'b00}`. `ins_e`=0 that cycle. `out_vld` is still driven, but a handshake in a redirect cycle is not a transfer.
- The buffer never overflows: the issue rule guarantees `count + infl <= DEPTH`. A push into a full buffer is a design error, flagged by an assertion in simulation.
- Reset (asynchronous, also mid-operation): `pc=RESET_PC`, `infl=0`, `count=0`, pointers 0.
- Reset values of outputs: `ins_e=0`, `ins_a=RESET_PC`, `out_vld=0`, `out_pc=0`, `out_ins=0`. Entries are cleared on reset.

## Timing
- Cycle 0 is the first cycle with `rst`=0:
  - `ins_e`=1 with `ins_a=RESET_PC`.
  - Cycle 1: `ins` holds the word and is pushed at the end of the cycle.
  - Cycle 2: `out_vld`=1.
- Fetch-to-output latency is 2 cycles. Throughput is 1 word/cycle with `out_rdy` held high and `DEPTH`>=2.
- Redirect asserted in cycle R:
  - Cycle R+1: first request to the new PC.
  - Cycle R+3: first new `out_vld`.
  - Cycles R+1 and R+2: `out_vld`=0.
- Backpressure: with `out_rdy`=0, the buffer fills to `DEPTH` and `ins_e` drops. `ins_e` re-asserts in the same cycle `out_rdy` returns (pop term).
- `out_*` are registered FIFO outputs. No combinational path runs from `ins`, `out_rdy` or `redirect` to `out_vld`/`out_pc`/`out_ins`. Combinational paths from `out_rdy` and `redirect` to `ins_e` do exist.

## Configuration
- `IFU_JAL_PREDECODE_EN` defined:
  - On push of a word with opcode 7'b1101111 (JAL), the next fetch PC becomes pushed-PC + J-immediate (truncated to 16 bits).
  - If a sequential request was issued in that same cycle, its response is discarded (`infl <= 0`), and `pc <= target`.
  - The JAL itself is still pushed and delivered normally.
  - An external redirect in the same cycle takes priority.
- Not defined: no predecode; JAL is fetched past sequentially and relies on `redirect`.

## Test plan
- Reset release, `RESET_PC`=16'h0000, `out_rdy`=1, SRAM words 0x00000013 at 0x0/0x4/0x8 -> out_vld first in cycle 2; out_pc sequence 0x0000, 0x0004, 0x0008 on consecutive cycles.
- `out_rdy`=0 from cycle 0 -> `ins_e` issues exactly `DEPTH` requests (2) then stays 0. Release `out_rdy` -> `ins_e`=1 in the same cycle; no word lost or duplicated.
- Redirect to 16'h0040 while the buffer holds 2 entries and one request is in flight -> next out_pc is 0x0040, 3 cycles later. Stale PCs 0x0008/0x000C never appear.
- Redirect with `out_vld`=`out_rdy`=1 in the same cycle -> the head is not consumed (the bench counts no transfer); the buffer is empty afterwards.
- Assert `rst` mid-stream with `ins_e`=1 -> outputs go to reset values immediately (asynchronously). After release, fetch restarts at `RESET_PC`.
- With `IFU_JAL_PREDECODE_EN`, JAL 0x0100006F (`jal x0,+16`) at 0x0004 -> out_pc sequence 0x0000, 0x0004, 0x0014; 0x0008 is never output. Without the macro -> 0x0000, 0x0004, 0x0008.
